ycr_sleep_ctrl: RTL and testbench
=================================

# ycr_sleep_ctrl

Core-side initiator of the clock-gate sleep protocol. Accepts a sleep command from the RISC-V core, checks that the gating mode is a wake-capable mode and no interrupt is already pending, and waits until the core bus has stayed quiet for a programmable number of cycles. It then raises a level `dst_idle` toward the source clock gate. On the gate's `wakeup` pulse it drops `dst_idle` and, after a settle window covering the gate's synchronizer and re-enable timer, signals `resume` to the core. Runs on the free-running (ungated) clock.

## Interface
- `DRAIN_CYCLES`, default 4: consecutive bus-idle cycles required before `dst_idle` asserts; legal range ≥1.
- `RESUME_CYCLES`, default 6: cycles from `wakeup` to the `resume` pulse; legal range ≥1. Must cover 2-flop sync plus the gate's 4-cycle timer.
- `clk_in` in 1: free-running clock.
- `reset` in 1: **one clock; reset is synchronous and active-high**.
- `sleep_req` in 1: one-cycle sleep command from the core (WFI).
- `cfg_mode` in 3: gating mode, using the same encoding as the clock gate.
  - 000 none, 001 IRQ1, 010 IRQ2, 011 IRQ3, 100 any IRQ, 101 force.
- `irq_pending` in 1: an interrupt is pending or being serviced (already synchronous).
- `bus_busy` in 1: outstanding instruction/data bus transaction.
- `wakeup` in 1: one-cycle pulse from the clock gate.
- `dst_idle` out 1: registered sleep request level to the clock gate.
- `sleep_ack` out 1: one-cycle pulse when `dst_idle` rises.
- `sleep_abort` out 1: one-cycle pulse when a request is rejected or cancelled.
- `resume` out 1: one-cycle pulse when the core may continue.
- `state_o` out 2: current FSM state, for debug.

## Operation
- States:
  - IDLE=00, DRAIN=01, SLEEP=10, RESUME=11.
  - One shared down-counter `cnt` of width $clog2(max(DRAIN_CYCLES,RESUME_CYCLES)+1).
- IDLE:
  - `sleep_req` with `cfg_mode` in 001..100 and `!irq_pending` → DRAIN, cnt=DRAIN_CYCLES.
  - `sleep_req` with any other mode, or with `irq_pending` → `sleep_abort` pulse; stay in IDLE.
- DRAIN:
  - `irq_pending` → `sleep_abort`, then IDLE. This has priority over everything else in DRAIN.
  - Else `bus_busy` → reload cnt=DRAIN_CYCLES.
  - Else if cnt==1 → SLEEP, `dst_idle`←1, `sleep_ack` pulse.
  - Else cnt←cnt−1.
- SLEEP:
  - `dst_idle` is held at 1.
  - `wakeup` → RESUME, `dst_idle`←0, cnt=RESUME_CYCLES.
  - `irq_pending`, `bus_busy`, `sleep_req` and `cfg_mode` changes are all ignored; wake is the gate's decision.
- RESUME:
  - cnt==1 → `resume` pulse, then IDLE.
  - Else cnt←cnt−1.
  - `sleep_req` is ignored.
- `wakeup` in any state other than SLEEP is ignored.
- `sleep_req` in any state other than IDLE is ignored; no pulse is generated.
- Reset (synchronous) from any state gives IDLE on the next edge: cnt=0, all outputs 0.
  - Consequence: a reset in SLEEP drops `dst_idle` without a `resume` pulse.

## Timing
- All outputs are registered. Reset values: `dst_idle`=0, `sleep_ack`=0, `sleep_abort`=0, `resume`=0, `state_o`=00.
- Entry to sleep: `sleep_req` sampled at edge N with the bus idle throughout.
  - Edge N: enter DRAIN.
  - Edges N+1 … N+DRAIN_CYCLES: count down.
  - `dst_idle` and `sleep_ack` high after edge N+DRAIN_CYCLES. `sleep_ack` lasts one cycle.
- Bus activity during DRAIN: a `bus_busy` cycle at edge K pushes the `dst_idle` rise to edge K+DRAIN_CYCLES at the earliest.
- Aborts:
  - Immediate abort (IDLE): `sleep_abort` high after edge N.
  - Abort in DRAIN: `sleep_abort` high the cycle after `irq_pending` is sampled.
- Exit from sleep: `wakeup` sampled at edge M.
  - `dst_idle` low after M.
  - `resume` high after edge M+RESUME_CYCLES, for one cycle.
- `dst_idle` low time: `dst_idle` stays low at least RESUME_CYCLES+1 cycles between sleeps. This guarantees the gate sees a fresh rising edge.
- Simultaneous events:
  - `irq_pending` on the final drain cycle → abort; `dst_idle` never rises.
  - `wakeup` on the same cycle as `dst_idle` rises is ignored, because the state is still DRAIN at that sample.

## Test plan
- Nominal cycle (defaults):
  - Stimulus: mode=001, bus idle, `sleep_req` at edge 10, `wakeup` pulse at edge 30.
  - Required: `dst_idle` and `sleep_ack` after edge 14; `dst_idle` low after 30; `resume` after edge 36; `state_o` back to 00.
- Bus drain restart:
  - Stimulus: `bus_busy` high at edges 12 and 13 of the nominal cycle.
  - Required: `dst_idle` rises after edge 17, not 14.
- Rejects:
  - Stimulus: `sleep_req` with mode=000, then mode=101, then mode=001 with `irq_pending`=1.
  - Required: three `sleep_abort` pulses, each one cycle after its request; `dst_idle` stays 0.
- Abort in drain:
  - Stimulus: `irq_pending` at edge 14 (the last drain cycle).
  - Required: `sleep_abort` after edge 14, IDLE, `dst_idle` never 1.
- Stray inputs:
  - Stimulus: `wakeup` pulses in IDLE and in DRAIN, and `sleep_req` in SLEEP and in RESUME.
  - Required: no state change and no output pulses.
- Reset in sleep:
  - Stimulus: `reset` held for 1 cycle at edge 20 while in SLEEP.
  - Required: all outputs 0 after edge 20, `state_o`=00, no `resume`; a subsequent `sleep_req` completes normally.

Source files
------------

// File: rtl/ycr_sleep_ctrl.sv
// Core-side initiator of the clock-gate sleep handshake: drains the bus, holds
// dst_idle toward the gate, and issues resume once the gate has re-enabled.
module ycr_sleep_ctrl #(
    parameter int unsigned DRAIN_CYCLES  = 4,
    parameter int unsigned RESUME_CYCLES = 6
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       sleep_req,
    input  logic [2:0] cfg_mode,
    input  logic       irq_pending,
    input  logic       bus_busy,
    input  logic       wakeup,
    output logic       dst_idle,
    output logic       sleep_ack,
    output logic       sleep_abort,
    output logic       resume,
    output logic [1:0] state_o
);

    localparam int unsigned CNT_MAX = (DRAIN_CYCLES > RESUME_CYCLES) ? DRAIN_CYCLES : RESUME_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] RESUME_LOAD = CNT_W'(RESUME_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DRAIN  = 2'b01,
        SLEEP  = 2'b10,
        RESUME = 2'b11
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ack_nxt;
    logic             abort_nxt;
    logic             resume_nxt;
    logic             mode_ok;

    // Only the IRQ-driven gating modes can ever wake the core again.
    assign mode_ok = (cfg_mode >= 3'd1) && (cfg_mode <= 3'd4);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        ack_nxt    = 1'b0;
        abort_nxt  = 1'b0;
        resume_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (sleep_req) begin
                    if (mode_ok && !irq_pending) begin
                        state_nxt = DRAIN;
                        cnt_nxt   = DRAIN_LOAD;
                    end else begin
                        abort_nxt = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (irq_pending) begin
                    abort_nxt = 1'b1;
                    state_nxt = IDLE;
                end else if (bus_busy) begin
                    cnt_nxt = DRAIN_LOAD;
                end else if (cnt == CNT_ONE) begin
                    state_nxt = SLEEP;
                    ack_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            SLEEP: begin
                // Wake is the gate's decision; core-side events are ignored here.
                if (wakeup) begin
                    state_nxt = RESUME;
                    cnt_nxt   = RESUME_LOAD;
                end
            end
            RESUME: begin
                if (cnt == CNT_ONE) begin
                    state_nxt  = IDLE;
                    resume_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            dst_idle    <= 1'b0;
            sleep_ack   <= 1'b0;
            sleep_abort <= 1'b0;
            resume      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            dst_idle    <= (state_nxt == SLEEP);
            sleep_ack   <= ack_nxt;
            sleep_abort <= abort_nxt;
            resume      <= resume_nxt;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_ycr_sleep_ctrl.sv
// Scoreboard bench for ycr_sleep_ctrl: per-cycle expectations from a small
// count-up model plus directed edge-timing checks from the nominal scenarios.
module tb_ycr_sleep_ctrl;

    localparam int DRAIN  = 4;
    localparam int RES    = 6;

    logic       clk_in = 1'b0;
    logic       reset = 1'b0;
    logic       sleep_req = 1'b0;
    logic [2:0] cfg_mode = 3'd0;
    logic       irq_pending = 1'b0;
    logic       bus_busy = 1'b0;
    logic       wakeup = 1'b0;
    logic       dst_idle;
    logic       sleep_ack;
    logic       sleep_abort;
    logic       resume;
    logic [1:0] state_o;

    ycr_sleep_ctrl #(.DRAIN_CYCLES(DRAIN), .RESUME_CYCLES(RES)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .sleep_req  (sleep_req),
        .cfg_mode   (cfg_mode),
        .irq_pending(irq_pending),
        .bus_busy   (bus_busy),
        .wakeup     (wakeup),
        .dst_idle   (dst_idle),
        .sleep_ack  (sleep_ack),
        .sleep_abort(sleep_abort),
        .resume     (resume),
        .state_o    (state_o)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic       dst;
        logic       ack;
        logic       abt;
        logic       res;
        logic [1:0] st;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: counts idle cycles up rather than down.
    int m_st = 0;
    int m_quiet = 0;
    int m_rt = 0;

    // Per-scenario observations
    int rise_e, fall_e, ack_e, res_e, abort_e;
    int n_ack, n_abort, n_res, n_dst;
    logic prev_dst;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic scen_start();
        rise_e = -1; fall_e = -1; ack_e = -1; res_e = -1; abort_e = -1;
        n_ack = 0; n_abort = 0; n_res = 0; n_dst = 0;
        prev_dst = 1'b0;
    endtask

    task automatic step(input int e, input logic sr, input logic [2:0] md,
                        input logic irq, input logic busy, input logic wk,
                        input logic rst);
        exp_t x;
        exp_t got;
        @(negedge clk_in);
        sleep_req = sr; cfg_mode = md; irq_pending = irq;
        bus_busy = busy; wakeup = wk; reset = rst;
        x = '0;
        if (rst) begin
            m_st = 0; m_quiet = 0; m_rt = 0;
        end else begin
            case (m_st)
                0: if (sr) begin
                    if (md >= 3'd1 && md <= 3'd4 && !irq) begin
                        m_st = 1; m_quiet = 0;
                    end else begin
                        x.abt = 1'b1;
                    end
                end
                1: if (irq) begin
                    x.abt = 1'b1; m_st = 0;
                end else if (busy) begin
                    m_quiet = 0;
                end else begin
                    m_quiet++;
                    if (m_quiet == DRAIN) begin
                        m_st = 2; x.ack = 1'b1;
                    end
                end
                2: if (wk) begin
                    m_st = 3; m_rt = 0;
                end
                default: begin
                    m_rt++;
                    if (m_rt == RES) begin
                        m_st = 0; x.res = 1'b1;
                    end
                end
            endcase
        end
        x.dst = (m_st == 2);
        x.st  = 2'(m_st);
        q.push_back(x);
        @(posedge clk_in);
        #1;
        if (q.size() != 0) begin
            x = q.pop_front();
            got = '{dst_idle, sleep_ack, sleep_abort, resume, state_o};
            if (got !== x)
                chk($sformatf("cyc%0d_outs", e), int'(got), int'(x));
            else
                total++;
        end
        if (dst_idle && !prev_dst) rise_e = e;
        if (!dst_idle && prev_dst) fall_e = e;
        prev_dst = dst_idle;
        if (dst_idle) n_dst++;
        if (sleep_ack) begin ack_e = e; n_ack++; end
        if (sleep_abort) begin abort_e = e; n_abort++; end
        if (resume) begin res_e = e; n_res++; end
    endtask

    initial begin
        // Reset state
        step(0, 0, 3'd0, 0, 0, 0, 1);
        chk("reset_state", int'(state_o), 0);
        chk("reset_dst", int'(dst_idle), 0);

        // Nominal cycle
        scen_start();
        for (int e = 1; e <= 40; e++) step(e, e == 10, 3'b001, 0, 0, e == 30, 0);
        chk("nom_rise", rise_e, 14);
        chk("nom_ack", ack_e, 14);
        chk("nom_fall", fall_e, 30);
        chk("nom_resume", res_e, 36);
        chk("nom_nres", n_res, 1);
        chk("nom_state", int'(state_o), 0);

        // Bus drain restart
        step(0, 0, 3'd0, 0, 0, 0, 1);
        scen_start();
        for (int e = 1; e <= 40; e++)
            step(e, e == 10, 3'b001, 0, (e == 12) || (e == 13), e == 30, 0);
        chk("busy_rise", rise_e, 17);
        chk("busy_resume", res_e, 36);

        // Rejects
        step(0, 0, 3'd0, 0, 0, 0, 1);
        scen_start();
        for (int e = 1; e <= 10; e++)
            step(e, (e == 2) || (e == 4) || (e == 6),
                 (e == 2) ? 3'b000 : (e == 4) ? 3'b101 : 3'b001, e == 6, 0, 0, 0);
        chk("rej_naborts", n_abort, 3);
        chk("rej_last_abort", abort_e, 6);
        chk("rej_dst", n_dst, 0);

        // Abort on the final drain cycle
        step(0, 0, 3'd0, 0, 0, 0, 1);
        scen_start();
        for (int e = 1; e <= 25; e++) step(e, e == 10, 3'b100, e == 14, 0, 0, 0);
        chk("drain_abort_e", abort_e, 14);
        chk("drain_abort_rise", rise_e, -1);
        chk("drain_abort_ack", n_ack, 0);

        // Stray wakeups and sleep requests
        step(0, 0, 3'd0, 0, 0, 0, 1);
        scen_start();
        for (int e = 1; e <= 40; e++)
            step(e, (e == 10) || (e == 20) || (e == 32), 3'b010, 0, 0,
                 (e == 3) || (e == 12) || (e == 14) || (e == 30), 0);
        chk("stray_rise", rise_e, 14);
        chk("stray_fall", fall_e, 30);
        chk("stray_resume", res_e, 36);
        chk("stray_aborts", n_abort, 0);
        chk("stray_acks", n_ack, 1);

        // Reset while sleeping, then a clean cycle
        step(0, 0, 3'd0, 0, 0, 0, 1);
        scen_start();
        for (int e = 1; e <= 24; e++) step(e, e == 10, 3'b011, 0, 0, 0, e == 20);
        chk("rst_fall", fall_e, 20);
        chk("rst_nres", n_res, 0);
        chk("rst_state", int'(state_o), 0);
        scen_start();
        for (int e = 25; e <= 45; e++) step(e, e == 25, 3'b011, 0, 0, e == 35, 0);
        chk("rst_again_rise", rise_e, 29);
        chk("rst_again_resume", res_e, 41);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
